// File: rtl/pipe_buffer_ctrl_if.sv
// Request/response bundle between a pipeline datapath and its buffer sequencer.
// master: the datapath side (issues redirects/stalls, consumes flush/hold/busy).
// slave:  the sequencer side (pipe_buffer_ctrl).
interface pipe_buffer_ctrl_if #(
  parameter int NUM_STAGES = 4,
  parameter int STG_W      = 2,
  parameter int CNT_W      = 4
) ();
  logic                  redirect;
  logic [STG_W-1:0]      redirect_stage;
  logic                  stall_req;
  logic [STG_W-1:0]      stall_stage;
  logic [CNT_W-1:0]      stall_len;
  logic [NUM_STAGES-1:0] flush;
  logic [NUM_STAGES-1:0] hold;
  logic                  busy;

  modport master (
    output redirect, redirect_stage, stall_req, stall_stage, stall_len,
    input  flush, hold, busy
  );

  modport slave (
    input  redirect, redirect_stage, stall_req, stall_stage, stall_len,
    output flush, hold, busy
  );
endinterface

// File: rtl/pipe_buffer_ctrl.sv
// pipe_buffer_ctrl: turns redirect pulses and stall requests into registered
// per-stage flush/hold strobes for a chain of buffer_memory stages (stage 0 youngest).
// Optional: define PIPE_CTRL_STATS_EN to add saturating stall_cnt/flush_cnt outputs.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | idle, flush=0 hold=0, accepting redirect or stall
// ST_STALL | holding stages 0..stall_stage, bubble above, cnt cycles left
// ST_FLUSH | flushing stages 0..redirect_stage, cnt cycles left
module pipe_buffer_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int STG_W      = 2,
  parameter int CNT_W      = 4,
  parameter int STALL_MAX  = 15,
  parameter int FLUSH_CYC  = 1
) (
  input  logic clk,
  input  logic rst,
  pipe_buffer_ctrl_if.slave bus
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] flush_q, flush_d;
  logic [NUM_STAGES-1:0] hold_q, hold_d;

  function automatic int clamp_stage(input logic [STG_W-1:0] s);
    int v;
    v = int'(s);
    if (v > NUM_STAGES - 1) v = NUM_STAGES - 1;
    return v;
  endfunction

  // Stages 0..s set.
  function automatic logic [NUM_STAGES-1:0] upto_mask(input logic [STG_W-1:0] s);
    logic [NUM_STAGES-1:0] m;
    int v;
    v = clamp_stage(s);
    for (int i = 0; i < NUM_STAGES; i++) m[i] = (i <= v);
    return m;
  endfunction

  // Only stage s+1 set (empty when s is the oldest stage), so it never overlaps upto_mask(s).
  function automatic logic [NUM_STAGES-1:0] bubble_mask(input logic [STG_W-1:0] s);
    logic [NUM_STAGES-1:0] m;
    int v;
    v = clamp_stage(s);
    for (int i = 0; i < NUM_STAGES; i++) m[i] = (i == v + 1);
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
    int v;
    v = int'(l);
    if (v > STALL_MAX) v = STALL_MAX;
    return CNT_W'(v);
  endfunction

  // State, counter and output strobes; everything visible is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      flush_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      hold_q  <= hold_d;
    end
  end

  // Next state: a redirect wins everywhere; a stall only starts from RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    hold_d  = hold_q;
    if (bus.redirect) begin
      state_d = ST_FLUSH;
      cnt_d   = CNT_W'(FLUSH_CYC);
      flush_d = upto_mask(bus.redirect_stage);
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.stall_req && (bus.stall_len != '0)) begin
            state_d = ST_STALL;
            cnt_d   = clamp_len(bus.stall_len);
            hold_d  = upto_mask(bus.stall_stage);
            flush_d = bubble_mask(bus.stall_stage);
          end
        end
        ST_STALL, ST_FLUSH: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            flush_d = '0;
            hold_d  = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
          flush_d = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign bus.flush = flush_q;
  assign bus.hold  = hold_q;
  assign bus.busy  = (state_q != ST_RUN);

`ifdef PIPE_CTRL_STATS_EN
  logic stall_go;
  logic redir_go;

  assign redir_go = bus.redirect;
  assign stall_go = (state_q == ST_RUN) && !bus.redirect && bus.stall_req &&
                    (bus.stall_len != '0);

  // Saturating event counters for accepted stalls and redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_go && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (redir_go && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
